configs_loader: RTL
===================

# configs_loader

Sequencer directly upstream of the configuration latch bank. It accepts a stream of 32-bit configuration words over a valid/ready handshake. For each word it drives the shared `io_d_out` bus and one-hot `io_configs_en` strobes with a fixed setup/strobe/hold pattern, so every transparent latch word captures clean, stable data. One load pass writes latch words 0..31 in order.

## Interface
Parameters: none. Widths are fixed to match the latch bank: 32-bit data, 32 words.

Ports:
- `clk`  in  1  — sole clock.
- `reset`  in  1  — synchronous, active-high.
- `io_start`  in  1  — begin a load pass. Sampled only in IDLE or DONE.
- `io_word_valid`  in  1  — upstream word available.
- `io_word`  in  32  — configuration word.
- `io_word_ready`  out  1  — block accepts `io_word` this cycle.
- `io_d_out`  out  32  — registered data bus to the latch bank `io_d_in`.
- `io_configs_en`  out  32  — registered one-hot latch enables.
- `io_index`  out  5  — latch word currently targeted.
- `io_busy`  out  1  — a pass is in progress.
- `io_done`  out  1  — pass complete. Held until the next start or reset.
- `io_err`  out  1  — checksum mismatch. Held with `io_done`.

## Operation
- States: IDLE, LOAD, SETUP, STROBE, HOLD, CHECK (present only with the macro), DONE.
- IDLE/DONE:
  - `io_start` causes: index←0, checksum accumulator←0, `io_done`←0, `io_err`←0, next state LOAD.
  - `io_start` in any other state is ignored.
- LOAD:
  - `io_word_ready`=1; it is combinational from the state and equals 1 in LOAD and CHECK only.
  - On valid&ready: `io_d_out`←`io_word`, accumulator ^= `io_word`, next state SETUP.
- SETUP: `io_configs_en`=0, data stable. Next state STROBE.
- STROBE: `io_configs_en` = 1<<index; exactly one bit set. Next state HOLD.
- HOLD: `io_configs_en`=0, `io_d_out` unchanged.
  - If index==31: next state CHECK with the macro, DONE without it.
  - Else: index←index+1, next state LOAD.
- `io_d_out` changes only on a LOAD acceptance, so it is stable from SETUP through HOLD. It is also held after HOLD.
- No en bit ever rises in the same cycle `io_d_out` changes.
- `io_busy`=1 in LOAD, SETUP, STROBE, HOLD, CHECK.
- Index does not wrap: pass ends after word 31. A new pass restarts at index 0.
- A reset mid-pass causes all outputs to return to reset values at that edge. `io_configs_en` drops to 0 immediately, and a partial latch write is abandoned. The latch bank contents are not cleared.
- Reset values: all outputs 0; state IDLE; index 0; accumulator 0.

## Timing
- Start sampled at edge S puts the block in LOAD; `io_word_ready` is high in the cycle after S.
- Word accepted at edge N:
  - N+1: SETUP, en=0.
  - N+2: STROBE, en bit high for exactly one cycle.
  - N+3: HOLD, en=0.
  - N+4: earliest next acceptance (after an N+3 return to LOAD).
- Throughput: 1 word per 4 cycles.
- With valid held high: word k is accepted at S+1+4k. Without the macro, `io_done` rises at S+128.
- `io_done`, `io_err`, `io_d_out`, `io_configs_en` and `io_index` are registered.

## Configuration
- `CFG_CHECKSUM_EN` defined:
  - After word 31, the block enters CHECK with ready=1.
  - On acceptance of a 33rd word: `io_err` ← (word != XOR of the 32 words), next state DONE.
  - No latch is strobed in CHECK.
  - `io_done` rises at S+129 when valid is held.
- Undefined:
  - No CHECK state, no accumulator.
  - `io_err` is tied 0.
  - HOLD of word 31 goes directly to DONE.

## Test plan
- Reset, then start and 32 back-to-back words 0x1000_0000+k: each en bit k pulses exactly one cycle. `io_d_out`=0x1000_0000+k from one cycle before until one cycle after the pulse. `io_done`=1 at S+128 (macro off).
- Valid toggled 1-0-1 with random gaps: ready is low outside LOAD. No word is dropped or duplicated. Strobe order is 0..31.
- Reset asserted during STROBE of word 5: next cycle en=0, `io_d_out`=0, busy=0, state IDLE. A new start restarts at index 0.
- `io_start` pulsed during LOAD of word 10: ignored; the pass continues to word 31 unchanged.
- Macro on, words all 0xA5A5_A5A5 (XOR=0), checksum 0x0000_0000: done=1, err=0. Repeat with checksum 0x0000_0001: done=1, err=1.
- Second pass after DONE: done and err clear the cycle after start. Index restarts at 0.

Source files
------------

// File: rtl/configs_loader.sv
// Feeds the configuration latch bank one word at a time with a setup/strobe/hold pattern.
// Optional CFG_CHECKSUM_EN adds a trailing XOR checksum word and the io_err flag.
module configs_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_start,
    input  logic        io_word_valid,
    input  logic [31:0] io_word,
    output logic        io_word_ready,
    output logic [31:0] io_d_out,
    output logic [31:0] io_configs_en,
    output logic [4:0]  io_index,
    output logic        io_busy,
    output logic        io_done,
    output logic        io_err
);

    // state    | meaning
    // S_IDLE   | waiting for io_start after reset
    // S_LOAD   | ready for the next configuration word
    // S_SETUP  | data on the bus, enables low
    // S_STROBE | one-hot enable pulse for the current index
    // S_HOLD   | enables low, data still stable
    // S_CHECK  | waiting for the checksum word (CFG_CHECKSUM_EN only)
    // S_DONE   | pass complete, results held until the next start
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
`ifdef CFG_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        io_word_ready = 1'b0;
        io_busy       = 1'b1;
        case (state)
            S_IDLE, S_DONE: begin
                io_busy = 1'b0;
                if (io_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                io_word_ready = 1'b1;
                if (io_word_valid) state_nxt = S_SETUP;
            end
            S_SETUP:  state_nxt = S_STROBE;
            S_STROBE: state_nxt = S_HOLD;
            S_HOLD: begin
                if (io_index != 5'd31) begin
                    state_nxt = S_LOAD;
                end else begin
`ifdef CFG_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            S_CHECK: begin
                io_word_ready = 1'b1;
                if (io_word_valid) state_nxt = S_DONE;
            end
`endif
            default: begin
                io_busy   = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign accept = io_word_valid & io_word_ready;

`ifdef CFG_CHECKSUM_EN
    logic [31:0] acc;
`else
    assign io_err = 1'b0;
`endif

    // Enable is launched from SETUP so it is high exactly while the state is STROBE.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_d_out      <= '0;
            io_configs_en <= '0;
            io_index      <= '0;
            io_done       <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            io_err        <= 1'b0;
            acc           <= '0;
`endif
        end else begin
            io_configs_en <= '0;
            if (state == S_SETUP) io_configs_en <= 32'd1 << io_index;

            if ((state == S_IDLE || state == S_DONE) && io_start) begin
                io_index <= '0;
                io_done  <= 1'b0;
`ifdef CFG_CHECKSUM_EN
                io_err   <= 1'b0;
                acc      <= '0;
`endif
            end

            if (state == S_LOAD && accept) begin
                io_d_out <= io_word;
`ifdef CFG_CHECKSUM_EN
                acc      <= acc ^ io_word;
`endif
            end

            if (state == S_HOLD) begin
                if (io_index != 5'd31) begin
                    io_index <= io_index + 5'd1;
                end else begin
`ifndef CFG_CHECKSUM_EN
                    io_done <= 1'b1;
`endif
                end
            end

`ifdef CFG_CHECKSUM_EN
            if (state == S_CHECK && accept) begin
                io_err  <= (io_word != acc);
                io_done <= 1'b1;
            end
`endif
        end
    end

endmodule
